// File: rtl/nn_pkg.sv
// rtl/nn_pkg.sv - activation format shared by the neuron, the output buffer and their benches
package nn_pkg;
  localparam int QM = 6;
  localparam int QN = 10;
  localparam int DW = QM + QN;

  typedef logic signed [DW-1:0] act_t;

  // Index width that stays legal when a layer has a single neuron.
  function automatic int idx_w(input int m);
    return (m > 1) ? $clog2(m) : 1;
  endfunction
endpackage

// File: rtl/layer_output_buffer_if.sv
// rtl/layer_output_buffer_if.sv - element input and vector output handshakes of the layer output buffer
interface layer_output_buffer_if import nn_pkg::*; #(
  parameter int M = 2
) ();
  logic              in_valid;
  logic              in_ready;
  act_t              in_data;
  logic              out_valid;
  logic              out_ready;
  act_t [M-1:0]      out_data;
  logic [1:0]        level;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, level
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, level
  );
endinterface

// File: rtl/layer_output_buffer_act_bank.sv
// rtl/layer_output_buffer_act_bank.sv - one M-element activation bank with its full flag
module act_bank import nn_pkg::*; #(
  parameter int M  = 2,
  parameter int IW = idx_w(M)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [IW-1:0] idx,
  input  act_t          wdata,
  input  logic          set_full,
  input  logic          clr_full,
  output logic          full,
  output act_t [M-1:0]  rdata
);
  act_t [M-1:0] mem;
  logic         full_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < M; k++) begin
        mem[k] <= '0;
      end
    end else if (we) begin
      mem[idx] <= wdata;
    end
  end

  // The top never sets and clears the same bank in one cycle; set wins if it did.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q <= 1'b0;
    end else if (set_full) begin
      full_q <= 1'b1;
    end else if (clr_full) begin
      full_q <= 1'b0;
    end
  end

  assign full  = full_q;
  assign rdata = mem;
endmodule

// File: rtl/layer_output_buffer.sv
// rtl/layer_output_buffer.sv - ping-pong buffer gathering M serial neuron outputs into one parallel vector
module layer_output_buffer import nn_pkg::*; #(
  parameter int M = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  layer_output_buffer_if.slave  bus
);
  localparam int IW = idx_w(M);
  localparam logic [IW-1:0] LAST_IDX = IW'(M - 1);

  logic          wr_bank;
  logic          rd_bank;
  logic [IW-1:0] wr_idx;
  logic [1:0]    level_q;

  logic [1:0]    full;
  logic [1:0]    we;
  logic [1:0]    set_full;
  logic [1:0]    clr_full;
  logic [1:0]    full_nxt;
  act_t [M-1:0]  rdata [2];

  logic          accept;
  logic          release_v;
  logic          frame_done;

  // Both handshake flags come straight from bank registers, so out_ready never reaches in_ready.
  assign bus.in_ready  = !full[wr_bank];
  assign bus.out_valid = full[rd_bank];
  assign bus.out_data  = rdata[rd_bank];
  assign bus.level     = level_q;

  assign accept     = bus.in_valid && bus.in_ready;
  assign release_v  = bus.out_valid && bus.out_ready;
  assign frame_done = accept && (wr_idx == LAST_IDX);

  always_comb begin
    we       = '0;
    set_full = '0;
    clr_full = '0;
    we[wr_bank]       = accept;
    set_full[wr_bank] = frame_done;
    clr_full[rd_bank] = release_v;
    for (int b = 0; b < 2; b++) begin
      full_nxt[b] = set_full[b] | (full[b] & ~clr_full[b]);
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    act_bank #(.M(M), .IW(IW)) u_bank (
      .clk      (clk),
      .rst      (rst),
      .we       (we[b]),
      .idx      (wr_idx),
      .wdata    (bus.in_data),
      .set_full (set_full[b]),
      .clr_full (clr_full[b]),
      .full     (full[b]),
      .rdata    (rdata[b])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_bank <= 1'b0;
      wr_idx  <= '0;
    end else if (accept) begin
      if (frame_done) begin
        wr_idx  <= '0;
        wr_bank <= ~wr_bank;
      end else begin
        wr_idx  <= wr_idx + IW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_bank <= 1'b0;
    end else if (release_v) begin
      rd_bank <= ~rd_bank;
    end
  end

  // Level tracks the flags' next values so it lines up with full[] after the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_q <= 2'd0;
    end else begin
      level_q <= {1'b0, full_nxt[0]} + {1'b0, full_nxt[1]};
    end
  end
endmodule

// File: tb/tb_layer_output_buffer.sv
// tb/tb_layer_output_buffer.sv - directed self-checking bench for layer_output_buffer (M=2, Q6.10)
module tb_layer_output_buffer;
  import nn_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  layer_output_buffer_if #(.M(2)) bus ();

  layer_output_buffer #(.M(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_vec(input string tag, input logic [15:0] e0, input logic [15:0] e1);
    check({tag, "_v"}, {15'd0, bus.out_valid}, 16'd1);
    check({tag, "_d0"}, bus.out_data[0], e0);
    check({tag, "_d1"}, bus.out_data[1], e1);
  endtask

  logic [15:0] cap0 [$];
  logic [15:0] cap1 [$];
  logic [9:0]  pat;
  int          acc;
  logic        exp_rdy;

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_valid", {15'd0, bus.out_valid}, 16'd0);
    check("rst_ready", {15'd0, bus.in_ready}, 16'd1);
    check("rst_level", {14'd0, bus.level}, 16'd0);
    check("rst_d0", bus.out_data[0], 16'h0000);
    check("rst_d1", bus.out_data[1], 16'h0000);
    rst = 1'b0;

    // Single frame
    @(negedge clk);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = 16'h0600;
    @(negedge clk);
    check("sf_mid_valid", {15'd0, bus.out_valid}, 16'd0);
    bus.in_data = 16'h0100;
    @(negedge clk);
    bus.in_valid = 1'b0;
    check_vec("sf", 16'h0600, 16'h0100);
    check("sf_level1", {14'd0, bus.level}, 16'd1);
    @(negedge clk);
    check("sf_after_valid", {15'd0, bus.out_valid}, 16'd0);
    check("sf_after_level", {14'd0, bus.level}, 16'd0);

    // Backpressure: A,B,C,D with D negative
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 16'h1111; @(negedge clk);
    bus.in_data   = 16'h2222; @(negedge clk);
    bus.in_data   = 16'h3333; @(negedge clk);
    bus.in_data   = 16'hC444; @(negedge clk);
    check("bp_level2", {14'd0, bus.level}, 16'd2);
    check("bp_ready0", {15'd0, bus.in_ready}, 16'd0);
    bus.in_data = 16'h5555;
    @(negedge clk);
    check("bp_fifth_ready", {15'd0, bus.in_ready}, 16'd0);
    check("bp_fifth_level", {14'd0, bus.level}, 16'd2);
    bus.in_valid  = 1'b0;
    check_vec("bp_ab", 16'h1111, 16'h2222);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("bp_ready1", {15'd0, bus.in_ready}, 16'd1);
    check("bp_level1", {14'd0, bus.level}, 16'd1);
    for (int i = 0; i < 3; i++) begin
      check_vec("bp_cd", 16'h3333, 16'hC444);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("bp_empty_level", {14'd0, bus.level}, 16'd0);
    check("bp_empty_valid", {15'd0, bus.out_valid}, 16'd0);

    // Simultaneous write completion and release
    for (int i = 0; i < 12; i++) begin
      if (i < 8) check("sim_ready", {15'd0, bus.in_ready}, 16'd1);
      check("sim_level_le1", {15'd0, bus.level <= 2'd1}, 16'd1);
      if (bus.out_valid && bus.out_ready) begin
        cap0.push_back(bus.out_data[0]);
        cap1.push_back(bus.out_data[1]);
      end
      bus.in_valid = (i < 8);
      bus.in_data  = 16'(i + 1);
      @(negedge clk);
    end
    check("sim_count", 16'(cap0.size()), 16'd4);
    for (int k = 0; k < 4 && k < cap0.size(); k++) begin
      check("sim_e0", cap0[k], 16'(2 * k + 1));
      check("sim_e1", cap1[k], 16'(2 * k + 2));
    end

    // Reset mid-frame
    bus.in_valid = 1'b1;
    bus.in_data  = 16'h7FFF;
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    #2;
    check("mrst_ready", {15'd0, bus.in_ready}, 16'd1);
    check("mrst_level", {14'd0, bus.level}, 16'd0);
    check("mrst_d0", bus.out_data[0], 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 16'h0200; @(negedge clk);
    bus.in_data   = 16'h0300; @(negedge clk);
    bus.in_valid  = 1'b0;
    check_vec("mrst_vec", 16'h0200, 16'h0300);

    // Hold stability while the other bank fills
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 16'h0AAA; @(negedge clk);
    bus.in_data   = 16'h0BBB; @(negedge clk);
    pat = 10'b0111001101;
    acc = 0;
    for (int i = 0; i < 10; i++) begin
      check_vec("hold", 16'h0AAA, 16'h0BBB);
      exp_rdy = (acc < 2);
      check("hold_ready", {15'd0, bus.in_ready}, {15'd0, exp_rdy});
      bus.in_valid = pat[i];
      bus.in_data  = 16'h0C00 + 16'(i);
      if (pat[i] && exp_rdy) acc++;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    check("hold_level", {14'd0, bus.level}, 16'd2);
    check_vec("hold_last", 16'h0AAA, 16'h0BBB);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check_vec("hold_next", 16'h0C00, 16'h0C02);
    check("hold_next_level", {14'd0, bus.level}, 16'd1);
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("hold_end_level", {14'd0, bus.level}, 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/layer_output_buffer.md
Name: layer_output_buffer

Overview:
- Downstream stage of the serial neuron.
- Collects M consecutive neuron outputs (fixed-point, QM integer / QN fraction bits, post-ReLU) into one M-element activation vector.
- Presents that vector in parallel to the next layer's `in` port with a valid/ready handshake.
- Ping-pong double buffering lets the neuron keep producing while the next layer consumes.

Parameters:
- M, 2: neurons per layer; equals the element count of the presented vector (next layer's N).
- QM, 6: integer bits of the activation format.
- QN, 10: fractional bits of the activation format.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset; asynchronous, active-high.
- in_valid  in  1  in_data holds a neuron output.
- in_ready  out  1  buffer can accept an element this cycle.
- in_data  in  QM+QN  signed neuron output.
- out_valid  out  1  a complete vector is available.
- out_ready  in  1  next layer accepts the vector.
- out_data  out  M x (QM+QN)  signed vector; element k is the k-th accepted input of its frame.
- level  out  2  number of full banks (0..2).

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values:
  - in_ready=1, out_valid=0, level=0.
  - out_data all zeros; both banks cleared.
  - wr_bank=0, rd_bank=0, wr_idx=0.
- Accept on in_valid&&in_ready:
  - bank[wr_bank][wr_idx] <= in_data.
  - If wr_idx==M-1: full[wr_bank]<=1, wr_idx<=0, wr_bank toggles.
  - Otherwise wr_idx increments.
- in_ready = !full[wr_bank], derived only from registered state. There is no combinational path from out_ready to in_ready.
- Output presentation:
  - out_valid = full[rd_bank].
  - out_data = bank[rd_bank], driven from registers.
- Release on out_valid&&out_ready: full[rd_bank]<=0, rd_bank toggles.
- Latency: the vector is visible with out_valid=1 in the cycle after the M-th element is accepted.
- Stability: while out_valid&&!out_ready, out_data and out_valid hold unchanged.
- Throughput: one element per cycle sustained, provided the consumer releases a vector at least every M cycles.
- Both banks full: wr_bank==rd_bank and in_ready=0.
  - A release in cycle t frees the bank; in_ready rises in t+1, giving one bubble by design.
- Simultaneous completion of a write frame and a release in the same cycle:
  - They always target different banks; both take effect.
  - level is unchanged (+1 -1).
- level = full[0]+full[1], registered. level==2 implies in_ready==0.
- Partial vector with in_valid idle: held indefinitely; there is no timeout.
- rst mid-frame or mid-handshake: partial data discarded, all state returns to reset values immediately (asynchronous).
- Data pass-through: no arithmetic, no saturation, no sign change. Negative values are stored as-is, even though the upstream neuron is ReLU.
- M==1: every accepted element completes a frame.

Decomposition:
- Shared package nn_pkg:
  - QM, QN.
  - localparam DW=QM+QN.
  - typedef logic signed [DW-1:0] act_t.
  - The same package also serves the neuron and its bench.
- Sub-module act_bank (one instance per bank):
  - Contents: M x act_t register array with write-enable and index, plus full flag set/clear.
  - Ports: clk, rst, we, idx, wdata, set_full, clr_full, full, rdata.
- Top level: holds wr_bank, rd_bank, wr_idx and the handshake logic.

Test Plan (M=2, QM=6, QN=10; 1.0 = 16'h0400):
- Reset check: assert rst with no stimulus -> out_valid=0, in_ready=1, level=0, out_data={0,0}.
- Single frame: write 16'h0600 (1.5), then 16'h0100 (0.25), out_ready=1 -> out_valid exactly one cycle after the 2nd accept, out_data[0]=16'h0600, out_data[1]=16'h0100; next cycle out_valid=0, level=0.
- Backpressure: out_ready=0, write 4 elements A,B,C,D in 4 cycles -> level=2 and in_ready=0 after the 4th; a 5th element is not accepted. Raise out_ready for 1 cycle -> {A,B} delivered; in_ready=1 the following cycle; {C,D} then presented and stable until released.
- Simultaneous: out_ready=1, continuous in_valid with values 1..8 -> four vectors {1,2},{3,4},{5,6},{7,8}, no loss or duplication, level never exceeds 1.
- Reset mid-frame: write one element 16'h7FFF, pulse rst -> in_ready=1, level=0. Next frame {16'h0200, 16'h0300} comes out as exactly that vector, with no trace of 16'h7FFF.
- Hold stability: vector presented with out_ready=0 for 10 cycles while in_valid is toggled randomly -> out_data unchanged every cycle; writes fill only the other bank.
